mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single shared instruction/data memory port of the multicycle core. It accepts access requests from the CPU control FSM (fetch and load/store states) and from a debug/loader port. It grants one requester at a time and holds the memory control lines for a configurable number of wait cycles. It returns read data with a one-cycle acknowledge, and the CPU FSM stalls in its current state until that acknowledge arrives.

---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the multicycle core's memory-port sequencer.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int LAT_DEFAULT        = 2;
    localparam int STREAK_MAX_DEFAULT = 4;

    // Bits needed to hold any value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational CPU/debug arbiter with a streak limit that forces a debug grant.
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEFAULT,
    parameter int SW         = cnt_width(STREAK_MAX)
) (
    input  logic          cpu_req_i,
    input  logic          dbg_req_i,
    input  logic [SW-1:0] streak_i,
    output logic          grant_valid_o,
    output owner_e        grant_owner_o,
    output logic [SW-1:0] next_streak_o
);

    always_comb begin
        grant_valid_o = cpu_req_i | dbg_req_i;
        grant_owner_o = OWN_CPU;
        next_streak_o = '0;
        if (cpu_req_i && dbg_req_i) begin
            // Streak only ever reaches STREAK_MAX, so the increment saturates there.
            if (streak_i == SW'(STREAK_MAX)) begin
                grant_owner_o = OWN_DBG;
                next_streak_o = '0;
            end else begin
                grant_owner_o = OWN_CPU;
                next_streak_o = streak_i + SW'(1);
            end
        end else if (dbg_req_i) begin
            grant_owner_o = OWN_DBG;
            next_streak_o = '0;
        end else begin
            grant_owner_o = OWN_CPU;
            next_streak_o = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer for the shared memory port: arbitrates CPU vs debug, holds the
// port for LAT cycles, then pulses the owner's ack for one cycle.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LAT        = LAT_DEFAULT,
    parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = $clog2(LAT + 1);
    localparam int SW = cnt_width(STREAK_MAX);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q;
    owner_e        owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    logic          grant_valid_s;
    owner_e        grant_owner_s;
    logic [SW-1:0] next_streak_s;
    logic          last_access_s;

    mem_arb_pick #(
        .STREAK_MAX (STREAK_MAX),
        .SW         (SW)
    ) u_pick (
        .cpu_req_i     (cpu_req),
        .dbg_req_i     (dbg_req),
        .streak_i      (streak_q),
        .grant_valid_o (grant_valid_s),
        .grant_owner_o (grant_owner_s),
        .next_streak_o (next_streak_s)
    );

    assign last_access_s = (state_q == ACCESS) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(LAT - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode only registered state and latched fields, never the requests.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            ACCESS: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                mem_we = we_q;
            end
            DONE: begin
                busy    = 1'b1;
                cpu_ack = (owner_q == OWN_CPU);
                dbg_ack = (owner_q == OWN_DBG);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q    <= '0;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                streak_q <= next_streak_s;
                if (grant_valid_s) begin
                    owner_q <= grant_owner_s;
                    if (grant_owner_s == OWN_DBG) begin
                        we_q    <= dbg_we;
                        addr_q  <= dbg_addr;
                        wdata_q <= dbg_wdata;
                    end else begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                    end
                end
            end
            // Read data is captured on the final access edge into the owner's register only.
            if (last_access_s && !we_q) begin
                if (owner_q == OWN_DBG) begin
                    dbg_rdata_q <= mem_rdata;
                end else begin
                    cpu_rdata_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transfer table, arbitration, reset and LAT=1 throughput.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          cpu_ack, dbg_ack, mem_en, mem_we, busy;

    logic          l1_cpu_req;
    logic          l1_zero_1;
    logic [AW-1:0] l1_zero_a;
    logic [DW-1:0] l1_zero_d, l1_mem_rdata;
    logic          l1_cpu_ack, l1_dbg_ack, l1_mem_en, l1_mem_we, l1_busy;
    logic [DW-1:0] l1_cpu_rdata, l1_dbg_rdata, l1_mem_wdata;
    logic [AW-1:0] l1_mem_addr;

    logic [DW-1:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STREAK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1), .STREAK_MAX(4)) u_lat1 (
        .clk(clk), .rst(rst),
        .cpu_req(l1_cpu_req), .cpu_we(l1_zero_1), .cpu_addr(l1_zero_a), .cpu_wdata(l1_zero_d),
        .cpu_ack(l1_cpu_ack), .cpu_rdata(l1_cpu_rdata),
        .dbg_req(l1_zero_1), .dbg_we(l1_zero_1), .dbg_addr(l1_zero_a), .dbg_wdata(l1_zero_d),
        .dbg_ack(l1_dbg_ack), .dbg_rdata(l1_dbg_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    // Word memory model: preloaded while rst is high, written when the port writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101;
            mem[4]  <= 32'hDEAD_BEEF;
            mem[5]  <= 32'h1111_1111;
            mem[15] <= 32'hCAFE_F00D;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        bit          dbg;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_cpu;
        logic [31:0] exp_dbg;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transfer on the LAT=2 DUT, checking port activity and ack timing cycle by cycle.
    task automatic xfer(input bit dbg, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit move_addr);
        @(negedge clk);
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        @(posedge clk);
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (move_addr && c == 1) cpu_addr = a + 32'd4;
            check("mem_en", 32'(mem_en), 32'(c <= LAT));
            check("busy", 32'(busy), 32'd1);
            if (c <= LAT) begin
                check("mem_addr", mem_addr, a);
                check("mem_we", 32'(mem_we), 32'(we));
                if (we) check("mem_wdata", mem_wdata, wd);
            end
            check("cpu_ack", 32'(cpu_ack), 32'((c == LAT + 1) && !dbg));
            check("dbg_ack", 32'(dbg_ack), 32'((c == LAT + 1) && dbg));
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    logic [9:0] exp_dbg_grant;
    int         n;

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        l1_cpu_req = 1'b0; l1_zero_1 = 1'b0; l1_zero_a = '0; l1_zero_d = '0;
        l1_mem_rdata = 32'h0BAD_CAFE;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        rst = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h20, 32'h0000_00A5, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h0000_00A5, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 32'h24, 32'h1234_5678, 32'h0000_00A5, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h24, 32'h0,         32'h0000_00A5, 32'h1234_5678};
        vecs[6] = '{1'b0, 1'b0, 32'h3C, 32'h0,         32'hCAFE_F00D, 32'h1234_5678};

        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i].dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
            check("vec_cpu_rdata", cpu_rdata, vecs[i].exp_cpu);
            check("vec_dbg_rdata", dbg_rdata, vecs[i].exp_dbg);
        end

        // Address moved mid-transfer must not reach the memory.
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
        check("latched_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Both requesters held: four CPU grants then one forced debug grant, repeating.
        exp_dbg_grant = 10'b10_0001_0000;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h3C;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            while (!(cpu_ack || dbg_ack) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("arb_dbg_grant", 32'(dbg_ack), 32'(exp_dbg_grant[g]));
            check("arb_cpu_grant", 32'(cpu_ack), 32'(!exp_dbg_grant[g]));
            @(negedge clk);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("arb_dbg_rdata", dbg_rdata, 32'hCAFE_F00D);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arb_idle", 32'(busy), 32'd0);

        // Reset in the second access cycle of a CPU write abandons it.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_en1", 32'(mem_en), 32'd1);
        @(negedge clk);
        check("rstmid_en2", 32'(mem_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ack", 32'(cpu_ack), 32'd0);
        check("rstmid_mem_en", 32'(mem_en), 32'd0);
        check("rstmid_mem_we", 32'(mem_we), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_mem_addr", mem_addr, 32'd0);
        check("rstmid_mem_wdata", mem_wdata, 32'd0);
        check("rstmid_cpu_rdata", cpu_rdata, 32'd0);
        check("rstmid_dbg_rdata", dbg_rdata, 32'd0);
        rst = 1'b0;
        cpu_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rstmid_no_ack", 32'(cpu_ack), 32'd0);
            check("rstmid_idle", 32'(busy), 32'd0);
        end

        // LAT=1 with request held: one transfer every three cycles.
        @(negedge clk);
        l1_cpu_req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("lat1_mem_en", 32'(l1_mem_en), 32'((k % 3) == 1));
            check("lat1_ack", 32'(l1_cpu_ack), 32'((k % 3) == 2));
            check("lat1_busy", 32'(l1_busy), 32'((k % 3) != 0));
            check("lat1_dbg_ack", 32'(l1_dbg_ack), 32'd0);
            if ((k % 3) == 2) check("lat1_rdata", l1_cpu_rdata, 32'h0BAD_CAFE);
        end
        l1_cpu_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
